conv_window_scheduler: RTL and testbench

Sequencing controller between the convolution window slider and the MAC engine in the NPU datapath. On `start` it arms the slider and requests windows one at a time. For each window it runs the MAC engine once per kernel, then writes each accumulated result into the output feature map (OFM) buffer at its computed address. It raises `done` when the full OUT_H×OUT_W×NUM_KERNELS output has been written.

---
 rtl/npu_pkg.sv | 31 +++
 rtl/ofm_addr_gen.sv | 91 +++++++++
 rtl/conv_window_scheduler.sv | 178 +++++++++++++++++
 tb/tb_conv_window_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: convolution output-size derivation and the
// window-scheduler FSM encoding.
package npu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_REQ      = 3'd2,
        ST_WAIT_WIN = 3'd3,
        ST_MAC      = 3'd4,
        ST_WAIT_MAC = 3'd5,
        ST_WRITE    = 3'd6,
        ST_DONE     = 3'd7
    } sched_state_t;

    // Number of window positions along one axis.
    function automatic int out_dim(input int img, input int k, input int stride);
        return ((img - k) / stride) + 32'sd1;
    endfunction

    // Number of windows in a full scan.
    function automatic int total_win(input int out_h, input int out_w);
        return out_h * out_w;
    endfunction

    // Counter/bus width for n values, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/ofm_addr_gen.sv
// Row/column/kernel/window counters for the window scheduler and the
// OFM address derived from them (kernel-major, then raster order).
module ofm_addr_gen
    import npu_pkg::*;
#(
    parameter int OUT_H       = 6,
    parameter int OUT_W       = 6,
    parameter int NUM_KERNELS = 2,
    parameter int KW          = clog2_min1(NUM_KERNELS),
    parameter int AW          = clog2_min1(NUM_KERNELS * OUT_H * OUT_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          win_accept,
    input  logic          step,
    output logic [KW-1:0] kernel,
    output logic          last_kernel,
    output logic          last_window,
    output logic [AW-1:0] addr
);

    localparam int TOTAL  = total_win(OUT_H, OUT_W);
    localparam int RW     = clog2_min1(OUT_H);
    localparam int CW     = clog2_min1(OUT_W);
    localparam int WW     = clog2_min1(TOTAL);
    localparam int LAST_K = NUM_KERNELS - 32'sd1;
    localparam int LAST_R = OUT_H - 32'sd1;
    localparam int LAST_C = OUT_W - 32'sd1;
    localparam int LAST_W = TOTAL - 32'sd1;

    localparam logic [AW-1:0] TOTAL_A = AW'(TOTAL);
    localparam logic [AW-1:0] OUT_W_A = AW'(OUT_W);

    logic [KW-1:0] kernel_r;
    logic [RW-1:0] row_r;
    logic [CW-1:0] col_r;
    logic [WW-1:0] win_cnt_r;
    logic          last_kernel_s;
    logic          last_col_s;
    logic          last_row_s;
    logic          last_window_s;
    logic [AW-1:0] addr_s;

    // Wrap detection and kernel*TOTAL + row*OUT_W + col at address width.
    always_comb begin
        last_kernel_s = (kernel_r == KW'(LAST_K));
        last_col_s    = (col_r == CW'(LAST_C));
        last_row_s    = (row_r == RW'(LAST_R));
        last_window_s = (win_cnt_r == WW'(LAST_W));
        addr_s        = (AW'(kernel_r) * TOTAL_A) + (AW'(row_r) * OUT_W_A) + AW'(col_r);
    end

    // Counters: cleared per pass, kernel rewinds on each new window,
    // raster position advances once all kernels of a window are written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kernel_r  <= '0;
            row_r     <= '0;
            col_r     <= '0;
            win_cnt_r <= '0;
        end else if (clear) begin
            kernel_r  <= '0;
            row_r     <= '0;
            col_r     <= '0;
            win_cnt_r <= '0;
        end else if (win_accept) begin
            // row/col already hold this window's position; only the kernel rewinds
            kernel_r <= '0;
        end else if (step) begin
            if (!last_kernel_s) begin
                kernel_r <= kernel_r + KW'(32'd1);
            end else begin
                kernel_r  <= '0;
                win_cnt_r <= win_cnt_r + WW'(32'd1);
                if (last_col_s) begin
                    col_r <= '0;
                    row_r <= last_row_s ? '0 : (row_r + RW'(32'd1));
                end else begin
                    col_r <= col_r + CW'(32'd1);
                end
            end
        end
    end

    assign kernel      = kernel_r;
    assign last_kernel = last_kernel_s;
    assign last_window = last_window_s;
    assign addr        = addr_s;

endmodule

// File: rtl/conv_window_scheduler.sv
// Sequences slider windows and per-kernel MAC runs, writing every result
// into the OFM buffer; flags protocol violations without aborting.
module conv_window_scheduler
    import npu_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 20,
    parameter int IMG_H       = 8,
    parameter int IMG_W       = 8,
    parameter int K_H         = 3,
    parameter int K_W         = 3,
    parameter int STRIDE_H    = 1,
    parameter int STRIDE_W    = 1,
    parameter int NUM_KERNELS = 2,
    localparam int OUT_H      = out_dim(IMG_H, K_H, STRIDE_H),
    localparam int OUT_W      = out_dim(IMG_W, K_W, STRIDE_W),
    localparam int KW         = clog2_min1(NUM_KERNELS),
    localparam int AW         = clog2_min1(NUM_KERNELS * OUT_H * OUT_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 win_start,
    output logic                 win_next,
    input  logic                 win_valid,
    input  logic                 win_all_done,
    output logic                 mac_start,
    output logic [KW-1:0]        mac_kernel,
    input  logic                 mac_done,
    input  logic [ACC_WIDTH-1:0] mac_result,
    output logic                 ofm_we,
    output logic [AW-1:0]        ofm_addr,
    output logic [ACC_WIDTH-1:0] ofm_wdata
);

    if (ACC_WIDTH < DATA_WIDTH) begin : g_bad_widths
        $error("conv_window_scheduler: ACC_WIDTH narrower than DATA_WIDTH");
    end

    sched_state_t         state_r, next_state_s;
    logic                 busy_r, done_r, error_r, win_start_r, win_next_r, mac_start_r, ofm_we_r;
    logic                 busy_s, done_s, error_s, win_start_s, win_next_s, mac_start_s, ofm_we_s;
    logic [AW-1:0]        ofm_addr_r, ofm_addr_s;
    logic [ACC_WIDTH-1:0] ofm_wdata_r, ofm_wdata_s;
    logic                 last_rcvd_r, last_rcvd_s;
    logic                 start_accept_s, win_accept_s, step_s, err_event_s;
    logic [KW-1:0]        kernel_s;
    logic                 last_kernel_s, last_window_s;
    logic [AW-1:0]        addr_s;

    ofm_addr_gen #(
        .OUT_H       (OUT_H),
        .OUT_W       (OUT_W),
        .NUM_KERNELS (NUM_KERNELS),
        .KW          (KW),
        .AW          (AW)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .clear       (start_accept_s),
        .win_accept  (win_accept_s),
        .step        (step_s),
        .kernel      (kernel_s),
        .last_kernel (last_kernel_s),
        .last_window (last_window_s),
        .addr        (addr_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; completion is driven by the window counter only.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:     next_state_s = start ? ST_ARM : ST_IDLE;
            ST_ARM:      next_state_s = ST_REQ;
            ST_REQ:      next_state_s = ST_WAIT_WIN;
            ST_WAIT_WIN: next_state_s = win_valid ? ST_MAC : ST_WAIT_WIN;
            ST_MAC:      next_state_s = ST_WAIT_MAC;
            ST_WAIT_MAC: next_state_s = mac_done ? ST_WRITE : ST_WAIT_MAC;
            ST_WRITE: begin
                if (!last_kernel_s) begin
                    next_state_s = ST_MAC;
                end else if (last_window_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_DONE:     next_state_s = ST_IDLE;
            default:     next_state_s = ST_IDLE;
        endcase
    end

    // Output decode: strobes follow the state being entered so every output is a flop.
    always_comb begin
        start_accept_s = (state_r == ST_IDLE) && start;
        win_accept_s   = (state_r == ST_WAIT_WIN) && win_valid;
        step_s         = (state_r == ST_WRITE);

        busy_s      = (next_state_s != ST_IDLE) && (next_state_s != ST_DONE);
        done_s      = (next_state_s == ST_DONE);
        win_start_s = (next_state_s == ST_ARM);
        win_next_s  = (next_state_s == ST_REQ);
        mac_start_s = (next_state_s == ST_MAC);
        ofm_we_s    = (next_state_s == ST_WRITE);

        if (next_state_s == ST_WRITE) begin
            ofm_addr_s  = addr_s;
            ofm_wdata_s = mac_result;
        end else begin
            ofm_addr_s  = ofm_addr_r;
            ofm_wdata_s = ofm_wdata_r;
        end

        // win_all_done alongside the last window's win_valid is still legal
        err_event_s = (win_valid && (state_r != ST_WAIT_WIN))
                   || (mac_done && (state_r != ST_WAIT_MAC))
                   || (win_all_done && !last_rcvd_r && !(win_accept_s && last_window_s));

        if (start_accept_s) begin
            error_s     = 1'b0;
            last_rcvd_s = 1'b0;
        end else begin
            error_s     = error_r | err_event_s;
            last_rcvd_s = last_rcvd_r | (win_accept_s & last_window_s);
        end
    end

    // Output and status registers; reset clears every strobe at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            win_start_r <= 1'b0;
            win_next_r  <= 1'b0;
            mac_start_r <= 1'b0;
            ofm_we_r    <= 1'b0;
            ofm_addr_r  <= '0;
            ofm_wdata_r <= '0;
            last_rcvd_r <= 1'b0;
        end else begin
            busy_r      <= busy_s;
            done_r      <= done_s;
            error_r     <= error_s;
            win_start_r <= win_start_s;
            win_next_r  <= win_next_s;
            mac_start_r <= mac_start_s;
            ofm_we_r    <= ofm_we_s;
            ofm_addr_r  <= ofm_addr_s;
            ofm_wdata_r <= ofm_wdata_s;
            last_rcvd_r <= last_rcvd_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign win_start  = win_start_r;
    assign win_next   = win_next_r;
    assign mac_start  = mac_start_r;
    assign mac_kernel = kernel_s;
    assign ofm_we     = ofm_we_r;
    assign ofm_addr   = ofm_addr_r;
    assign ofm_wdata  = ofm_wdata_r;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: slider and MAC responders, scoreboard of
// expected OFM writes, directed scenarios on an 8x8/stride-1 instance (A)
// and a 5x5/stride-2 instance (B).
module tb_conv_window_scheduler;
    import npu_pkg::*;

    localparam int NK    = 2;
    localparam int TOT_A = 36;
    localparam int TOT_B = 4;

    typedef struct packed {
        logic [6:0]  addr;
        logic [19:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start        [2];
    logic        busy         [2];
    logic        done         [2];
    logic        error        [2];
    logic        win_start    [2];
    logic        win_next     [2];
    logic        win_valid    [2];
    logic        win_all_done [2];
    logic        mac_start    [2];
    logic [0:0]  mac_kernel   [2];
    logic        mac_done     [2];
    logic [19:0] mac_result   [2];
    logic        ofm_we       [2];
    logic [19:0] ofm_wdata    [2];
    logic [6:0]  addr_a;
    logic [2:0]  addr_b;

    int errors = 0;
    int checks = 0;

    int sl_cnt [2], widx [2], cur_win [2], mac_cnt [2], mac_k [2], k_exp [2], ad_cnt [2];
    int writes [2], done_cnt [2], first_addr [2], mdkind [2];
    bit vprev [2], prev_we [2];
    bit inj_md, inj_ad;
    int wcnt_a [72];
    int wcnt_b [8];
    logic [19:0] mem_a [72];
    exp_t sb_a [$];
    exp_t sb_b [$];

    always #5 clk = ~clk;

    conv_window_scheduler dut_a (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]), .error(error[0]),
        .win_start(win_start[0]), .win_next(win_next[0]), .win_valid(win_valid[0]),
        .win_all_done(win_all_done[0]), .mac_start(mac_start[0]), .mac_kernel(mac_kernel[0]),
        .mac_done(mac_done[0]), .mac_result(mac_result[0]), .ofm_we(ofm_we[0]),
        .ofm_addr(addr_a), .ofm_wdata(ofm_wdata[0])
    );

    conv_window_scheduler #(
        .IMG_H(5), .IMG_W(5), .K_H(3), .K_W(3), .STRIDE_H(2), .STRIDE_W(2), .NUM_KERNELS(2)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]), .error(error[1]),
        .win_start(win_start[1]), .win_next(win_next[1]), .win_valid(win_valid[1]),
        .win_all_done(win_all_done[1]), .mac_start(mac_start[1]), .mac_kernel(mac_kernel[1]),
        .mac_done(mac_done[1]), .mac_result(mac_result[1]), .ofm_we(ofm_we[1]),
        .ofm_addr(addr_b), .ofm_wdata(ofm_wdata[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One negedge step of the slider/MAC responders and the write monitor for instance d.
    task automatic model_step(input int d);
        int   a;
        int   tot;
        int   pending;
        exp_t e;
        tot = (d == 0) ? TOT_A : TOT_B;
        win_valid[d]    = 1'b0;
        win_all_done[d] = 1'b0;
        mac_done[d]     = 1'b0;
        if (rst) begin
            sl_cnt[d] = 0; mac_cnt[d] = 0; ad_cnt[d] = 0;
            prev_we[d] = 1'b0; vprev[d] = 1'b0; mdkind[d] = 0;
            if (d == 0) sb_a.delete(); else sb_b.delete();
            return;
        end
        // monitor
        if (vprev[d]) check("mac_start_after_valid", mac_start[d], 1);
        if (mdkind[d] != 0) check("we_after_mac_done", ofm_we[d], (mdkind[d] == 1) ? 1 : 0);
        vprev[d] = 1'b0;
        mdkind[d] = 0;
        if (ofm_we[d]) begin
            a = (d == 0) ? int'(addr_a) : int'(addr_b);
            if (writes[d] == 0) first_addr[d] = a;
            writes[d]++;
            pending = (d == 0) ? sb_a.size() : sb_b.size();
            check("write_expected", (pending != 0) ? 1 : 0, 1);
            if (pending != 0) begin
                e = (d == 0) ? sb_a.pop_front() : sb_b.pop_front();
                check("ofm_addr", a, e.addr);
                check("ofm_wdata", ofm_wdata[d], e.data);
            end
            if (d == 0 && a < 72) begin
                wcnt_a[a]++;
                mem_a[a] = ofm_wdata[0];
            end else if (d == 1 && a < 8) begin
                wcnt_b[a]++;
            end
        end
        if (done[d]) begin
            done_cnt[d]++;
            check("done_after_last_we", prev_we[d], 1);
            check("busy_low_at_done", busy[d], 0);
            check("writes_at_done", writes[d], NK * tot);
        end
        prev_we[d] = ofm_we[d];
        // slider
        if (ad_cnt[d] > 0) begin
            ad_cnt[d]--;
            if (ad_cnt[d] == 0) win_all_done[d] = 1'b1;
        end
        if (win_start[d]) begin
            widx[d] = 0; sl_cnt[d] = 0; k_exp[d] = NK;
        end
        if (win_next[d]) begin
            check("no_next_mid_window", k_exp[d], NK);
            sl_cnt[d] = 3;
        end else if (sl_cnt[d] > 0) begin
            sl_cnt[d]--;
            if (sl_cnt[d] == 1 && d == 0 && inj_md) begin
                mac_done[0] = 1'b1;
                mac_result[0] = 20'hABCDE;
                mdkind[0] = 2;
                inj_md = 1'b0;
            end
            if (sl_cnt[d] == 0) begin
                win_valid[d] = 1'b1;
                vprev[d] = 1'b1;
                cur_win[d] = widx[d];
                widx[d]++;
                k_exp[d] = 0;
                if (widx[d] == tot) ad_cnt[d] = 1;
                if (d == 0 && inj_ad && widx[0] == 6) begin
                    ad_cnt[0] = 1;
                    inj_ad = 1'b0;
                end
            end
        end
        // MAC engine, 4-cycle latency, result = 100*kernel + window index
        if (mac_start[d]) begin
            check("mac_kernel", mac_kernel[d], k_exp[d]);
            mac_k[d] = k_exp[d];
            k_exp[d]++;
            mac_cnt[d] = 4;
        end else if (mac_cnt[d] > 0) begin
            mac_cnt[d]--;
            if (mac_cnt[d] == 0) begin
                check("mac_kernel_stable", mac_kernel[d], mac_k[d]);
                mac_done[d] = 1'b1;
                mac_result[d] = 20'(100 * mac_k[d] + cur_win[d]);
                mdkind[d] = 1;
                e.addr = 7'(mac_k[d] * tot + cur_win[d]);
                e.data = mac_result[d];
                if (d == 0) sb_a.push_back(e); else sb_b.push_back(e);
            end
        end
    endtask

    initial begin : responders
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) model_step(d);
        end
    end

    task automatic clear_pass(input int d);
        writes[d] = 0;
        done_cnt[d] = 0;
        first_addr[d] = -1;
        for (int i = 0; i < 72; i++) wcnt_a[i] = 0;
        for (int i = 0; i < 8; i++) wcnt_b[i] = 0;
    endtask

    task automatic pulse_start(input int d);
        @(negedge clk);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input string tag);
        int n;
        n = 0;
        while (done_cnt[d] == 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_done_in_budget"}, (done_cnt[d] != 0) ? 1 : 0, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_pass(input int d, input int exp_err, input string tag);
        int bad;
        int tot;
        tot = (d == 0) ? TOT_A : TOT_B;
        bad = 0;
        for (int i = 0; i < NK * tot; i++) begin
            if (((d == 0) ? wcnt_a[i] : wcnt_b[i]) != 1) bad++;
        end
        check({tag, "_writes"}, writes[d], NK * tot);
        check({tag, "_addr_once"}, bad, 0);
        check({tag, "_done_count"}, done_cnt[d], 1);
        check({tag, "_sb_drained"}, (d == 0) ? sb_a.size() : sb_b.size(), 0);
        check({tag, "_error"}, error[d], exp_err);
        check({tag, "_busy_idle"}, busy[d], 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy[0], 0);
        check({tag, "_done"}, done[0], 0);
        check({tag, "_error"}, error[0], 0);
        check({tag, "_win_start"}, win_start[0], 0);
        check({tag, "_win_next"}, win_next[0], 0);
        check({tag, "_mac_start"}, mac_start[0], 0);
        check({tag, "_mac_kernel"}, mac_kernel[0], 0);
        check({tag, "_ofm_we"}, ofm_we[0], 0);
        check({tag, "_ofm_addr"}, addr_a, 0);
        check({tag, "_ofm_wdata"}, ofm_wdata[0], 0);
        check({tag, "_state_idle"}, dut_a.state_r, ST_IDLE);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main_seq
        int n;
        rst = 1'b1;
        inj_md = 1'b0;
        inj_ad = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; win_valid[d] = 1'b0; win_all_done[d] = 1'b0;
            mac_done[d] = 1'b0; mac_result[d] = 20'd0;
            clear_pass(d);
        end
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        check("reset_busy_b", busy[1], 0);
        @(negedge clk);
        #1 rst = 1'b0;

        // nominal pass with start/arm/request timing
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        check("t1_win_start", win_start[0], 1);
        check("t1_busy", busy[0], 1);
        check("t1_win_next_early", win_next[0], 0);
        @(negedge clk);
        check("t1_win_next", win_next[0], 1);
        check("t1_win_start_off", win_start[0], 0);
        wait_done(0, "t1");
        check_pass(0, 0, "t1");
        check("t1_addr37", mem_a[37], 101);

        // spurious mac_done while waiting for a window
        clear_pass(0);
        inj_md = 1'b1;
        pulse_start(0);
        wait_done(0, "t2");
        check("t2_injected", inj_md, 0);
        check_pass(0, 1, "t2");

        // new start clears error; re-pulsed start mid-pass is ignored
        clear_pass(0);
        pulse_start(0);
        check("t3_error_cleared", error[0], 0);
        repeat (60) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        check("t3_busy_kept", busy[0], 1);
        check("t3_error_kept_low", error[0], 0);
        wait_done(0, "t3");
        check_pass(0, 0, "t3");

        // early win_all_done after window 5
        clear_pass(0);
        inj_ad = 1'b1;
        pulse_start(0);
        n = 0;
        while (widx[0] < 7 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check("t4_error_set", error[0], 1);
        check("t4_no_early_done", done_cnt[0], 0);
        wait_done(0, "t4");
        check_pass(0, 1, "t4");

        // reset during WAIT_MAC of window 10
        clear_pass(0);
        pulse_start(0);
        n = 0;
        while (!(mac_cnt[0] == 3 && cur_win[0] == 10 && busy[0]) && n < 4000) begin
            @(posedge clk);
            n++;
        end
        check("t5_reached_win10", (mac_cnt[0] == 3 && cur_win[0] == 10) ? 1 : 0, 1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_outputs_zero("t5_rst");
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        clear_pass(0);
        repeat (6) @(negedge clk);
        check("t5_quiet_writes", writes[0], 0);
        check("t5_quiet_busy", busy[0], 0);
        pulse_start(0);
        wait_done(0, "t6");
        check_pass(0, 0, "t6");
        check("t6_first_addr", first_addr[0], 0);

        // 5x5 image, 3x3 kernel, stride 2
        clear_pass(1);
        pulse_start(1);
        wait_done(1, "tb");
        check_pass(1, 0, "tb");
        check("tb_first_addr", first_addr[1], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
